// File: rtl/riscv_pkg.sv
// Shared definitions for the load-store unit: funct3 size codes and FSM states.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Load lane extractor: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it. Size low bits pick the width (00 byte, 01 half,
// anything else word); size bit 2 selects zero extension.
import riscv_pkg::*;

module riscv_lsu_load_align (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    output logic [31:0] o_ext32
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    assign w_signed = ~i_size[2];

    // Select the addressed byte and half lanes.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_off)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        // Misaligned halves are not trapped; only off[1] matters.
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extend the selected lane to 32 bits according to width and signedness.
    always_comb begin
        o_ext32 = i_word;
        case (i_size[1:0])
            2'b00:   o_ext32 = {{24{w_signed & w_byte[7]}}, w_byte};
            2'b01:   o_ext32 = {{16{w_signed & w_half[15]}}, w_half};
            default: o_ext32 = i_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: accepts one core access, latches it, runs a single memory
// transaction with byte enables, and returns the extended load result on the
// completion cycle. The core is stalled for the whole access.
import riscv_pkg::*;

module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    lsu_state_t  r_state;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wd;

    logic        w_busy;
    logic        w_done;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] w_ext;

    assign w_busy = (r_state == BUSY);
    assign w_done = w_busy & mem_ready_i;
    assign w_off  = r_addr[1:0];

    // Handshake FSM: latch the request in IDLE, wait for memory in BUSY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= 32'h0;
            r_wd    <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (core_req_i) begin
                        r_we    <= core_we_i;
                        r_size  <= core_size_i;
                        r_addr  <= core_addr_i;
                        r_wd    <= core_wd_i;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Store shaping: replicate data across lanes and enable only the target bytes.
    always_comb begin
        w_be = 4'b1111;
        w_wd = r_wd;
        if (r_we) begin
            case (r_size[1:0])
                2'b00: begin
                    w_be = 4'b0001 << w_off;
                    w_wd = {4{r_wd[7:0]}};
                end
                2'b01: begin
                    w_be = w_off[1] ? 4'b1100 : 4'b0011;
                    w_wd = {2{r_wd[15:0]}};
                end
                default: begin
                    w_be = 4'b1111;
                    w_wd = r_wd;
                end
            endcase
        end
    end

    riscv_lsu_load_align u_load_align (
        .i_word  (mem_rd_i),
        .i_off   (w_off),
        .i_size  (r_size),
        .o_ext32 (w_ext)
    );

    // Memory side is quiet outside BUSY, so reset (which forces IDLE
    // asynchronously) drops every memory output at once.
    assign mem_req_o    = w_busy;
    assign mem_we_o     = w_busy & r_we;
    assign mem_be_o     = w_busy ? w_be : 4'b0000;
    assign mem_addr_o   = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_wd_o     = (w_busy & r_we) ? w_wd : 32'h0;

    assign core_rd_o    = w_done ? w_ext : 32'h0;
    assign core_stall_o = ~rst_i & (w_busy ? ~mem_ready_i : core_req_i);

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: stores, loads with every extension mode,
// delayed ready, ignored inputs and reset in the middle of an access.
module tb_riscv_lsu;

    logic        clk_i;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int checks;
    int errors;
    int stall_cycles;

    riscv_lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request in IDLE, check the IDLE stall, advance into BUSY.
    task automatic issue(input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'b0;
        #1;
        chk("idle_stall", {31'b0, core_stall_o}, 32'h1);
        chk("idle_no_memreq", {31'b0, mem_req_o}, 32'h0);
        step();
        core_req_i  = 1'b0;
    endtask

    // In BUSY: raise ready, check the load result and the released stall, finish.
    task automatic complete_load(input string tag, input logic [31:0] rd, input logic [31:0] exp);
        mem_rd_i    = rd;
        mem_ready_i = 1'b1;
        #1;
        chk({tag, "_rd"}, core_rd_o, exp);
        chk({tag, "_stall"}, {31'b0, core_stall_o}, 32'h0);
        step();
        mem_ready_i = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_i        = 1'b1;
        core_req_i   = 1'b1;
        core_we_i    = 1'b0;
        core_size_i  = 3'b000;
        core_addr_i  = 32'h0;
        core_wd_i    = 32'h0;
        mem_rd_i     = 32'h0;
        mem_ready_i  = 1'b0;

        // Reset state: every output low even with a request pending.
        #2;
        chk("rst_stall", {31'b0, core_stall_o}, 32'h0);
        chk("rst_memreq", {31'b0, mem_req_o}, 32'h0);
        chk("rst_rd", core_rd_o, 32'h0);
        chk("rst_be", {28'b0, mem_be_o}, 32'h0);
        core_req_i = 1'b0;
        step();
        rst_i = 1'b0;
        step();

        // mem_ready in IDLE is ignored.
        mem_ready_i = 1'b1;
        #1;
        chk("idle_ready_memreq", {31'b0, mem_req_o}, 32'h0);
        chk("idle_ready_rd", core_rd_o, 32'h0);
        chk("idle_ready_stall", {31'b0, core_stall_o}, 32'h0);
        mem_ready_i = 1'b0;
        step();

        // SW 0x104: ready on the first BUSY cycle.
        issue(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
        mem_ready_i = 1'b1;
        #1;
        chk("sw_memreq", {31'b0, mem_req_o}, 32'h1);
        chk("sw_we", {31'b0, mem_we_o}, 32'h1);
        chk("sw_addr", mem_addr_o, 32'h0000_0104);
        chk("sw_be", {28'b0, mem_be_o}, 32'hF);
        chk("sw_wd", mem_wd_o, 32'hDEAD_BEEF);
        chk("sw_stall", {31'b0, core_stall_o}, 32'h0);
        step();
        mem_ready_i = 1'b0;
        #1;
        chk("sw_after_memreq", {31'b0, mem_req_o}, 32'h0);
        chk("sw_after_stall", {31'b0, core_stall_o}, 32'h0);

        // SB 0x203 (back-to-back with the previous completion).
        issue(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5);
        chk("sb_addr", mem_addr_o, 32'h0000_0200);
        chk("sb_be", {28'b0, mem_be_o}, 32'h8);
        chk("sb_wd", mem_wd_o, 32'hA5A5_A5A5);
        chk("sb_busy_stall", {31'b0, core_stall_o}, 32'h1);
        complete_load("sb", 32'h0, 32'h0);

        // SB 0x101 -> lane 1.
        issue(1'b1, 3'b000, 32'h0000_0101, 32'h0000_003C);
        chk("sb1_be", {28'b0, mem_be_o}, 32'h2);
        chk("sb1_wd", mem_wd_o, 32'h3C3C_3C3C);
        complete_load("sb1", 32'h0, 32'h0);

        // SH 0x202 -> upper half.
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234);
        chk("sh_be", {28'b0, mem_be_o}, 32'hC);
        chk("sh_wd", mem_wd_o, 32'h1234_1234);
        chk("sh_addr", mem_addr_o, 32'h0000_0200);
        complete_load("sh", 32'h0, 32'h0);

        // Loads from the word 0x80FF7F01.
        issue(1'b0, 3'b000, 32'h0000_0203, 32'h0);
        chk("lb_we", {31'b0, mem_we_o}, 32'h0);
        chk("lb_be", {28'b0, mem_be_o}, 32'hF);
        chk("lb_addr", mem_addr_o, 32'h0000_0200);
        complete_load("lb", 32'h80FF_7F01, 32'hFFFF_FF80);

        issue(1'b0, 3'b100, 32'h0000_0203, 32'h0);
        complete_load("lbu", 32'h80FF_7F01, 32'h0000_0080);

        issue(1'b0, 3'b001, 32'h0000_0202, 32'h0);
        complete_load("lh", 32'h80FF_7F01, 32'hFFFF_80FF);

        issue(1'b0, 3'b101, 32'h0000_0200, 32'h0);
        complete_load("lhu", 32'h80FF_7F01, 32'h0000_7F01);

        issue(1'b0, 3'b000, 32'h0000_0201, 32'h0);
        complete_load("lb_pos", 32'h80FF_7F01, 32'h0000_007F);

        // Misaligned word ignores the offset; size 111 treated as word.
        issue(1'b0, 3'b111, 32'h0000_0106, 32'h0);
        chk("lw_mis_addr", mem_addr_o, 32'h0000_0104);
        complete_load("lw_mis", 32'h80FF_7F01, 32'h80FF_7F01);

        // LW with ready delayed 3 cycles; core_addr changes mid-wait.
        stall_cycles = 1;
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 3; i++) begin
            core_addr_i = 32'h0000_0500 + i;
            mem_rd_i    = 32'h1111_1111;
            #1;
            if (core_stall_o) stall_cycles++;
            chk("lw_wait_addr", mem_addr_o, 32'h0000_0300);
            chk("lw_wait_rd", core_rd_o, 32'h0);
            step();
        end
        chk("lw_stall_count", stall_cycles, 32'd4);
        complete_load("lw_delay", 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Reset in the middle of a store aborts it immediately.
        issue(1'b1, 3'b010, 32'h0000_0400, 32'h5555_AAAA);
        chk("abort_pre_memreq", {31'b0, mem_req_o}, 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("abort_memreq", {31'b0, mem_req_o}, 32'h0);
        chk("abort_we", {31'b0, mem_we_o}, 32'h0);
        chk("abort_stall", {31'b0, core_stall_o}, 32'h0);
        chk("abort_addr", mem_addr_o, 32'h0);
        chk("abort_wd", mem_wd_o, 32'h0);
        chk("abort_be", {28'b0, mem_be_o}, 32'h0);
        step();
        rst_i = 1'b0;
        step();
        chk("post_rst_idle", {31'b0, mem_req_o}, 32'h0);

        // Next request after reset completes normally.
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        chk("post_rst_addr", mem_addr_o, 32'h0000_0010);
        complete_load("post_rst", 32'h1122_3344, 32'h1122_3344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load-store unit between `riscv_core` and `data_mem` inside `riscv_unit`. It accepts one load or store per core request, stalls the core while the access is in flight, and turns byte/half/word requests into word-aligned memory transactions with byte enables. On loads it extracts, sign- or zero-extends, and returns the addressed lane. It is a two-state handshake FSM with registered request fields.

## Interface
- No parameters; datapath fixed at 32 bits, address 32 bits.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `core_req_i` in 1: core requests a memory access this cycle.
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: funct3 code, LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- `core_addr_i` in 32: byte address.
- `core_wd_i` in 32: store data, right-aligned.
- `core_rd_o` out 32: extended load result.
- `core_stall_o` out 1: core must hold PC and the request.
- `mem_req_o` out 1: memory transaction valid.
- `mem_we_o` out 1: memory write.
- `mem_be_o` out 4: byte enables for writes.
- `mem_addr_o` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wd_o` out 32: lane-replicated write data.
- `mem_rd_i` in 32: read word, valid when `mem_ready_i`=1.
- `mem_ready_i` in 1: memory completes the transaction this cycle.

## Operation
- FSM states are IDLE and BUSY. Reset enters IDLE.
- **IDLE**
  - `core_req_i`=1: `core_stall_o`=1 (combinational), latch we/size/addr/wd into registers, go to BUSY.
  - `core_req_i`=0: `core_stall_o`=0, stay in IDLE.
- **BUSY**
  - `mem_req_o`=1 and all `mem_*` are driven from the latched registers.
  - `mem_ready_i`=0: `core_stall_o`=1, stay in BUSY.
  - `mem_ready_i`=1: `core_stall_o`=0 and `core_rd_o` is valid in the same cycle, go to IDLE.
- Byte offset is `off = addr[1:0]`.
- **Store shaping**
  - SB: `be = 4'b0001 << off`, `wd = {4{wd[7:0]}}`.
  - SH: `be = off[1] ? 4'b1100 : 4'b0011`, `wd = {2{wd[15:0]}}`.
  - SW: `be = 4'b1111`, `wd = wd`.
- **Load extraction** from `mem_rd_i`
  - LB/LBU: byte at `off`, sign-/zero-extended.
  - LH/LHU: half selected by `off[1]`, sign-/zero-extended.
  - LW: full word.
- Sizes 011, 110, 111 are treated as word.
- Misaligned access is not trapped: the half uses `off[1]` and the word ignores `off`.
- For loads `mem_be_o` = 4'b1111. `mem_we_o`/`mem_be_o`/`mem_wd_o` matter only when `mem_req_o`=1.
- `core_rd_o` = 0 outside the BUSY&`mem_ready_i` cycle.

## Timing
- Minimum access takes 2 cycles: the request cycle in IDLE, then BUSY with `mem_ready_i`=1. The core advances on the second edge.
- Each extra cycle with `mem_ready_i`=0 adds one stall cycle; there is no timeout.
- Back-to-back: a new `core_req_i` in the cycle after completion is accepted normally, with IDLE stall again. There is at most one outstanding transaction.
- `mem_ready_i` in IDLE is ignored.
- Changes on `core_*` while in BUSY are ignored because fields are latched.
- Reset values: state=IDLE, latched registers=0.
- All outputs are 0 while `rst_i`=1, including `core_stall_o`.
- Reset asserted mid-BUSY aborts the access: `mem_req_o` drops asynchronously and there is no write completion guarantee.

## Structure
- Shared package `riscv_pkg` holds the size codes `LDST_B`, `LDST_H`, `LDST_W`, `LDST_BU`, `LDST_HU` and the state enum `lsu_state_t` (IDLE, BUSY).
- One sub-module: `riscv_lsu_load_align`, a combinational load extractor with inputs word, off, size and output ext32.
- Store shaping stays inline.
- Integration: `riscv_unit` inserts `riscv_lsu` between core and `data_mem`, with core `size_o` feeding `core_size_i`.

## Test plan
- SW addr 0x104, wd 0xDEADBEEF, ready on the first BUSY cycle -> `mem_addr_o`=0x104, be=1111, wd=0xDEADBEEF; stall high for 1 cycle only.
- SB addr 0x203, wd 0x000000A5 -> `mem_addr_o`=0x200, be=1000, wd=0xA5A5A5A5.
- SH addr 0x202, wd 0x1234 -> be=1100, wd=0x12341234.
- Load with `mem_rd_i`=0x80FF7F01:
  - LB off 3 -> 0xFFFFFF80.
  - LBU off 3 -> 0x00000080.
  - LH off 2 -> 0xFFFF80FF.
  - LHU off 0 -> 0x00007F01.
- LW with `mem_ready_i` delayed 3 cycles -> stall held 4 cycles total; `core_addr_i` changed mid-wait does not alter `mem_addr_o`; result equals `mem_rd_i` on the ready cycle.
- `rst_i` pulsed during BUSY -> all outputs 0 immediately; state IDLE; next request completes normally.
